// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one shared 4-bit ALU serving two requesters.
// A round-robin grant is taken in IDLE. The winner's operands are latched,
// the ALU runs for one cycle in EXEC, and the 8-bit result is then held on
// rsp_data in RESP. It stays there until the winner takes it or the hold
// window runs out. Completed operations are counted per requester with
// saturating counters. Timed-out results set a sticky drop flag.
module alu_share_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  input  logic [1:0]       fn0,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  input  logic [1:0]       fn1,
  output logic [1:0]       ack,
  output logic [1:0]       rsp_valid,
  output logic [7:0]       rsp_data,
  input  logic [1:0]       rsp_ready,
  output logic             busy,
  output logic [1:0]       drop_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int              HOLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;   // requester that won the previous contest
  logic              grant;        // requester owning the op in flight
  logic              win;          // winner of the contest in this IDLE cycle
  logic              take;         // latch operands of win at this edge
  logic              done_ok;      // result handshaken this cycle
  logic              done_drop;    // result abandoned this cycle
  logic [3:0]        a_q;
  logic [3:0]        b_q;
  logic [1:0]        fn_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        alu_res;

  // Round-robin pick: on a tie, the requester that did not win last time.
  always_comb begin
    if (req == 2'b11) win = ~last_grant;
    else              win = req[1];
  end

  // ALU on the latched operands.
  always_comb begin
    unique case (fn_q)
      2'd0:    alu_res = {3'b000, {1'b0, a_q} + {1'b0, b_q}};
      2'd1:    alu_res = {7'b0, |(a_q | b_q)};
      2'd2:    alu_res = {7'b0, &(a_q & b_q)};
      default: alu_res = {a_q, b_q};
    endcase
  end

  // Next-state and handshake outputs; reset masks the combinational strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt = state;
    ack       = 2'b00;
    rsp_valid = 2'b00;
    take      = 1'b0;
    done_ok   = 1'b0;
    done_drop = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          take      = 1'b1;
          ack[win]  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          done_drop = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      ack       = 2'b00;
      rsp_valid = 2'b00;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping, operand latch, result register and hold timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      fn_q       <= 2'd0;
      rsp_data   <= 8'h00;
      hold_cnt   <= '0;
    end else begin
      if (take) begin
        grant      <= win;
        last_grant <= win;
        a_q        <= win ? a1  : a0;
        b_q        <= win ? b1  : b0;
        fn_q       <= win ? fn1 : fn0;
      end
      if (state == EXEC) begin
        rsp_data <= alu_res;
        hold_cnt <= '0;
      end else if (state == RESP) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Sticky drop flags and saturating completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 2'b00;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      if (done_drop) drop_err[grant] <= 1'b1;
      if (done_ok) begin
        if (!grant && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
        if (grant  && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. A transaction-level model is updated on every
// rising edge and checked against the DUT on every falling edge. Directed
// scenarios add literal expectations, and a randomized phase follows them.
module tb_alu_share_arbiter;

  localparam int HOLD_MAX = 5;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [3:0]       a0, b0, a1, b1;
  logic [1:0]       fn0, fn1;
  logic [1:0]       ack;
  logic [1:0]       rsp_valid;
  logic [7:0]       rsp_data;
  logic [1:0]       rsp_ready;
  logic             busy;
  logic [1:0]       drop_err;
  logic [CNT_W-1:0] cnt0, cnt1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .fn0       (fn0),
    .a1        (a1),
    .b1        (b1),
    .fn1       (fn1),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .drop_err  (drop_err),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the function table.
  function automatic int alu_ref(input int a, input int b, input int fn);
    case (fn)
      0:       return a + b;
      1:       return ((a | b) != 0) ? 1 : 0;
      2:       return ((a & b) == 15) ? 1 : 0;
      default: return a * 16 + b;
    endcase
  endfunction

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return (r == 2'b10) ? 1 : 0;
  endfunction

  // Transaction model: one op in flight, its owner, age since grant and result.
  bit m_init   = 1'b0;
  bit m_active = 1'b0;
  int m_who    = 0;
  int m_age    = 0;
  int m_last   = 1;
  int m_res    = 0;
  int m_data   = 0;
  bit [1:0] m_drop = 2'b00;
  int m_cnt [2] = '{0, 0};
  int m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_init   = 1'b1;
      m_active = 1'b0;
      m_last   = 1;
      m_data   = 0;
      m_drop   = 2'b00;
      m_cnt    = '{0, 0};
    end else if (m_init) begin
      if (!m_active) begin
        if (req != 2'b00) begin
          m_w      = pick(req, m_last);
          m_res    = (m_w == 1) ? alu_ref(int'(a1), int'(b1), int'(fn1))
                                : alu_ref(int'(a0), int'(b0), int'(fn0));
          m_who    = m_w;
          m_last   = m_w;
          m_active = 1'b1;
          m_age    = 0;
        end
      end else if (m_age == 0) begin
        m_data = m_res;
        m_age  = 1;
      end else if (rsp_ready[m_who]) begin
        if (m_cnt[m_who] < CNT_MAX) m_cnt[m_who]++;
        m_active = 1'b0;
      end else if (m_age == HOLD_MAX) begin
        m_drop[m_who] = 1'b1;
        m_active      = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    logic [1:0] exp_ack;
    logic [1:0] exp_valid;
    if (m_init) begin
      exp_ack   = 2'b00;
      exp_valid = 2'b00;
      if (!rst && !m_active && req != 2'b00) exp_ack = 2'(1 << pick(req, m_last));
      if (!rst && m_active && m_age >= 1)    exp_valid = 2'(1 << m_who);
      check("ack",       ack,       exp_ack);
      check("rsp_valid", rsp_valid, exp_valid);
      check("rsp_data",  rsp_data,  m_data);
      check("busy",      busy,      m_active);
      check("drop_err",  drop_err,  m_drop);
      check("cnt0",      cnt0,      m_cnt[0]);
      check("cnt1",      cnt1,      m_cnt[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Full single-requester op with literal checks; starts and ends just after a rising edge.
  task automatic do_op(input int who, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] fn, input logic [7:0] exp);
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    req = oh;
    if (who == 1) begin a1 = a; b1 = b; fn1 = fn; end
    else          begin a0 = a; b0 = b; fn0 = fn; end
    rsp_ready = oh;
    @(negedge clk);
    check("op_ack", ack, oh);
    step();
    req = 2'b00;
    step();
    @(negedge clk);
    check("op_valid", rsp_valid, oh);
    check("op_data",  rsp_data,  exp);
    step();
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; rsp_ready = 2'b00;
    a0 = 4'h0; b0 = 4'h0; fn0 = 2'd0; a1 = 4'h0; b1 = 4'h0; fn1 = 2'd0;

    // 1: reset state, then 4'hF + 4'h1 from requester 0.
    step();
    step();
    @(negedge clk);
    check("rst_busy", busy,     1'b0);
    check("rst_data", rsp_data, 8'h00);
    check("rst_drop", drop_err, 2'b00);
    check("rst_cnt0", cnt0,     2'd0);
    step();
    rst = 1'b0; req = 2'b01; a0 = 4'hF; b0 = 4'h1; fn0 = 2'd0;
    @(negedge clk);
    check("t1_ack", ack, 2'b01);
    step();
    req = 2'b00;
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_valid_exec", rsp_valid, 2'b00);
    step();
    rsp_ready = 2'b01;
    @(negedge clk);
    check("t1_valid", rsp_valid, 2'b01);
    check("t1_data",  rsp_data,  8'h10);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("t1_cnt0", cnt0, 2'd1);
    step();

    // 2: both requesting continuously, grants alternate starting with 0.
    do_reset();
    req = 2'b11; rsp_ready = 2'b11;
    a0 = 4'hA; b0 = 4'h5; fn0 = 2'd3;
    a1 = 4'hF; b1 = 4'hF; fn1 = 2'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_ack", ack, (k % 2) ? 2'b10 : 2'b01);
      step();
      step();
      @(negedge clk);
      check("t2_valid", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      check("t2_data",  rsp_data,  (k % 2) ? 8'h01 : 8'hA5);
      step();
    end

    // 3: reduce operations on edge operands.
    do_op(0, 4'h0, 4'h0, 2'd1, 8'h00);
    do_op(0, 4'hF, 4'hE, 2'd2, 8'h00);
    do_op(1, 4'h9, 4'h7, 2'd0, 8'h10);

    // 4: requester 1 result never taken; ready[0] must be ignored.
    req = 2'b10; a1 = 4'h3; b1 = 4'h4; fn1 = 2'd0; rsp_ready = 2'b00;
    @(negedge clk);
    check("t4_ack", ack, 2'b10);
    step();
    req = 2'b00; rsp_ready = 2'b01;
    step();
    for (int i = 0; i < HOLD_MAX; i++) begin
      @(negedge clk);
      check("t4_valid", rsp_valid, 2'b10);
      step();
    end
    @(negedge clk);
    check("t4_drop",  drop_err,  2'b10);
    check("t4_busy",  busy,      1'b0);
    check("t4_valid_after", rsp_valid, 2'b00);
    check("t4_cnt1",  cnt1,      2'd3);
    check("t4_cnt0",  cnt0,      2'd3);
    step();
    rsp_ready = 2'b00;

    // 5: reset while EXEC; next contest with both requesting goes to 0.
    req = 2'b10; a1 = 4'h1; b1 = 4'h1; fn1 = 2'd0;
    step();
    rst = 1'b1; req = 2'b00;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ack",   ack,       2'b00);
    check("t5_valid", rsp_valid, 2'b00);
    check("t5_busy",  busy,      1'b0);
    check("t5_drop",  drop_err,  2'b00);
    step();
    req = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    check("t5_grant", ack, 2'b01);
    step();
    req = 2'b00;
    step();
    step();
    rsp_ready = 2'b00;

    // 6: counter saturation at CNT_W bits.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      do_op(0, 4'(k), 4'h1, 2'd0, 8'(k + 1));
      @(negedge clk);
      check("t6_cnt0", cnt0, (k < CNT_MAX) ? k : CNT_MAX);
      step();
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      req       = 2'($urandom);
      a0        = 4'($urandom);
      b0        = 4'($urandom);
      fn0       = 2'($urandom);
      a1        = 4'($urandom);
      b1        = 4'($urandom);
      fn1       = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; req = 2'b00; rsp_ready = 2'b11;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
